// File: rtl/root_sched_pkg.sv
// Shared types and widths for the root request scheduler.
// Contents: operand/result widths and the scheduler state enum.
package root_sched_pkg;

  localparam int IN1_W = 10;  // radicand width, Q10.0
  localparam int IN2_W = 3;   // root degree width
  localparam int OUT_W = 20;  // engine result width, Q10.10

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - priority pointer; the search starts at this index and wraps
//   grant - one-hot grant of the first requester at or after ptr, zero if none
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found_s;
  logic [PTR_W-1:0] idx_s;

  // Scan upward from the pointer, wrapping, and keep the first requester found.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx_s = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/root_req_sched.sv
// Shares one root engine among NUM_REQ requesters, one job in flight at a time.
// A round-robin arbiter picks a requester in IDLE; its operands are latched,
// issued to the engine with a one-cycle start pulse, and the result is
// returned on the response channel tagged with the requester index.
// Degree-0 jobs are answered immediately with rsp_err and never reach the engine.
// Ports:
//   clk, rst_n                          - clock, synchronous active-low reset
//   req_valid/req_data_1/req_data_2     - per-requester request (radicand, degree)
//   req_ready                           - one-hot-or-zero accept, IDLE only
//   eng_in_valid/eng_in_data_1/_2       - engine start pulse and operands
//   eng_out_valid/eng_out_data          - engine result strobe and value
//   eng_rst_n                           - engine synchronous active-low reset
//   rsp_valid/rsp_id/rsp_data/rsp_err   - response, held until rsp_ready
// Build option: define ROOT_SCHED_TIMEOUT_EN to add a WAIT watchdog of
// TIMEOUT_CYC cycles that resets the engine and returns an error response.
module root_req_sched
  import root_sched_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int TIMEOUT_CYC = 255,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IN1_W-1:0] req_data_1,
  input  logic [NUM_REQ*IN2_W-1:0] req_data_2,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     eng_in_valid,
  output logic [IN1_W-1:0]         eng_in_data_1,
  output logic [IN2_W-1:0]         eng_in_data_2,
  input  logic                     eng_out_valid,
  input  logic [OUT_W-1:0]         eng_out_data,
  output logic                     eng_rst_n,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [OUT_W-1:0]         rsp_data,
  output logic                     rsp_err,
  input  logic                     rsp_ready
);

  sched_state_e     state_r, state_nxt_s;
  logic [ID_W-1:0]  ptr_r, id_r, gnt_idx_s;
  logic [IN1_W-1:0] op1_r, sel_d1_s;
  logic [IN2_W-1:0] op2_r, sel_d2_s;
  logic [OUT_W-1:0] rsp_data_r;
  logic             rsp_err_r;
  logic [NUM_REQ-1:0] grant_s;
  logic             accept_s;
  logic             timeout_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  // Encode the one-hot grant into an index for operand selection.
  always_comb begin
    gnt_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        gnt_idx_s = ID_W'(i);
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
  end

  assign sel_d1_s = req_data_1[gnt_idx_s*IN1_W +: IN1_W];
  assign sel_d2_s = req_data_2[gnt_idx_s*IN2_W +: IN2_W];

`ifdef ROOT_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt_r;
  logic             eng_rst_r;

  // A result arriving on the last watchdog cycle still wins over the timeout.
  assign timeout_s = (state_r == ST_WAIT) && !eng_out_valid &&
                     (wait_cnt_r == CNT_W'(TIMEOUT_CYC - 1));

  // WAIT cycle counter and the one-cycle engine reset pulse on timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_r <= '0;
      eng_rst_r  <= 1'b1;
    end else begin
      eng_rst_r <= !timeout_s;
      if ((state_r == ST_WAIT) && !eng_out_valid && !timeout_s) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= '0;
      end
    end
  end

  assign eng_rst_n = rst_n & eng_rst_r;
`else
  assign timeout_s = 1'b0;
  assign eng_rst_n = rst_n;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt_s  = state_r;
    accept_s     = 1'b0;
    req_ready    = '0;
    eng_in_valid = 1'b0;
    rsp_valid    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Gate with rst_n so no transfer is signalled while reset holds.
        req_ready = rst_n ? grant_s : '0;
        if (|grant_s) begin
          accept_s    = 1'b1;
          state_nxt_s = (sel_d2_s == '0) ? ST_RESP : ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        eng_in_valid = rst_n;
        state_nxt_s  = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_out_valid || timeout_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Job context: operands, owner, pointer and the response payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r      <= '0;
      id_r       <= '0;
      op1_r      <= '0;
      op2_r      <= '0;
      rsp_data_r <= '0;
      rsp_err_r  <= 1'b0;
    end else if (accept_s) begin
      ptr_r      <= ID_W'((int'(gnt_idx_s) + 1) % NUM_REQ);
      id_r       <= gnt_idx_s;
      op1_r      <= sel_d1_s;
      op2_r      <= sel_d2_s;
      rsp_data_r <= '0;
      rsp_err_r  <= (sel_d2_s == '0);
    end else if ((state_r == ST_WAIT) && eng_out_valid) begin
      rsp_data_r <= eng_out_data;
      rsp_err_r  <= 1'b0;
    end else if (timeout_s) begin
      rsp_data_r <= '0;
      rsp_err_r  <= 1'b1;
    end else begin
      rsp_data_r <= rsp_data_r;
      rsp_err_r  <= rsp_err_r;
    end
  end

  // Operands stay on the engine bus for the whole job so the engine can
  // keep sampling the degree while it computes.
  assign eng_in_data_1 = (state_r == ST_IDLE) ? '0 : op1_r;
  assign eng_in_data_2 = (state_r == ST_IDLE) ? '0 : op2_r;
  assign rsp_id        = id_r;
  assign rsp_data      = rsp_data_r;
  assign rsp_err       = rsp_err_r;

endmodule

// File: tb/tb_root_req_sched.sv
module tb_root_req_sched;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*10-1:0] req_data_1;
  logic [N*3-1:0]  req_data_2;
  logic [N-1:0]    req_ready;
  logic            eng_in_valid;
  logic [9:0]      eng_in_data_1;
  logic [2:0]      eng_in_data_2;
  logic            eng_out_valid;
  logic [19:0]     eng_out_data;
  logic            eng_rst_n;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [19:0]     rsp_data;
  logic            rsp_err;
  logic            rsp_ready;

  always #5 clk = ~clk;

  root_req_sched #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data_1    (req_data_1),
    .req_data_2    (req_data_2),
    .req_ready     (req_ready),
    .eng_in_valid  (eng_in_valid),
    .eng_in_data_1 (eng_in_data_1),
    .eng_in_data_2 (eng_in_data_2),
    .eng_out_valid (eng_out_valid),
    .eng_out_data  (eng_out_data),
    .eng_rst_n     (eng_rst_n),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .rsp_ready     (rsp_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a job is either waiting to be issued, out at the engine,
  // or waiting for its response to be taken; none of these means idle.
  int   m_ptr, m_id, m_d1, m_d2, m_rdata, m_wcnt;
  bit   m_issue, m_wait, m_resp, m_rerr, m_erst_pulse;

  // Engine stand-in and observation records.
  bit          eng_busy, eng_silent, eng_force, spur_en;
  int          eng_cnt, eng_lat_max;
  logic [19:0] eng_res, eng_force_val;
  int          n_issue, n_rsp, n_erst;
  int          grants[$];
  int          last_id, last_data;
  bit          last_err;

  task automatic model_reset();
    m_ptr = 0; m_id = 0; m_d1 = 0; m_d2 = 0; m_rdata = 0; m_wcnt = 0;
    m_issue = 0; m_wait = 0; m_resp = 0; m_rerr = 0; m_erst_pulse = 0;
    eng_busy = 0;
  endtask

  // One clock cycle: drive engine, check outputs, advance model, move to next negedge.
  task automatic step();
    int g;
    bit idle;
    logic [N-1:0] exp_ready;
    eng_out_valid = 1'b0;
    eng_out_data  = '0;
    if (eng_busy && !eng_silent) begin
      if (eng_cnt == 0) begin
        eng_out_valid = 1'b1; eng_out_data = eng_res; eng_busy = 0;
      end else eng_cnt--;
    end else if (!eng_busy && spur_en && $urandom_range(0, 7) == 0) begin
      eng_out_valid = 1'b1; eng_out_data = 20'($urandom);
    end
    #1;
    idle = !(m_issue || m_wait || m_resp);
    g = -1;
    if (idle) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    if (!rst_n) begin
      check_eq("eng_rst_n_in_reset", 32'(eng_rst_n), 32'd0);
      check_eq("req_ready_in_reset", 32'(req_ready), 32'd0);
    end else begin
      check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
      check_eq("eng_in_valid", 32'(eng_in_valid), 32'(m_issue));
      check_eq("eng_in_data_1", 32'(eng_in_data_1), idle ? 32'd0 : 32'(m_d1));
      check_eq("eng_in_data_2", 32'(eng_in_data_2), idle ? 32'd0 : 32'(m_d2));
      check_eq("eng_rst_n", 32'(eng_rst_n), 32'(!m_erst_pulse));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      if (m_resp) begin
        check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
        check_eq("rsp_data", 32'(rsp_data), 32'(m_rdata));
        check_eq("rsp_err", 32'(rsp_err), 32'(m_rerr));
      end
      for (int k = 0; k < N; k++) if (req_ready[k]) grants.push_back(k);
      if (!eng_rst_n) n_erst++;
      if (eng_in_valid) begin
        n_issue++;
        eng_busy = 1;
        eng_cnt  = $urandom_range(0, eng_lat_max);
        eng_res  = eng_force ? eng_force_val : 20'($urandom);
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++; last_id = int'(rsp_id); last_data = int'(rsp_data); last_err = rsp_err;
      end
    end
    m_erst_pulse = 0;
    if (!rst_n) begin
      model_reset();
    end else if (idle) begin
      if (g >= 0) begin
        m_id = g; m_d1 = int'(req_data_1[g*10 +: 10]); m_d2 = int'(req_data_2[g*3 +: 3]);
        m_ptr = (g + 1) % N;
        if (m_d2 == 0) begin m_resp = 1; m_rerr = 1; m_rdata = 0; end
        else m_issue = 1;
      end
    end else if (m_issue) begin
      m_issue = 0; m_wait = 1; m_wcnt = 0;
    end else if (m_wait) begin
      if (eng_out_valid) begin
        m_wait = 0; m_resp = 1; m_rerr = 0; m_rdata = int'(eng_out_data);
      end
`ifdef ROOT_SCHED_TIMEOUT_EN
      else if (m_wcnt == TO - 1) begin
        m_wait = 0; m_resp = 1; m_rerr = 1; m_rdata = 0; m_erst_pulse = 1; eng_busy = 0;
      end else m_wcnt++;
`endif
    end else if (m_resp && rsp_ready) begin
      m_resp = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_order[5];
    logic [19:0] hold_data;
    logic [1:0]  hold_id;
    logic        hold_err;
    exp_order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0; req_valid = '0; req_data_1 = '0; req_data_2 = '0; rsp_ready = 1'b1;
    eng_out_valid = 1'b0; eng_out_data = '0;
    eng_silent = 0; eng_force = 0; eng_force_val = '0; spur_en = 0; eng_lat_max = 3;
    n_issue = 0; n_rsp = 0; n_erst = 0; last_id = -1; last_data = -1; last_err = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset values
    #1;
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("reset_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("reset_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("reset_eng_in_valid", 32'(eng_in_valid), 32'd0);
    check_eq("reset_eng_in_data_1", 32'(eng_in_data_1), 32'd0);

    // Port 0: radicand 16, degree 2, engine returns 0x01000
    eng_force = 1; eng_force_val = 20'h01000; n_issue = 0; n_rsp = 0;
    req_valid = 4'b0001; req_data_1[9:0] = 10'd16; req_data_2[2:0] = 3'd2;
    step();
    req_valid = '0;
    for (int i = 0; i < 12; i++) step();
    eng_force = 0;
    check_eq("p0_issue_count", 32'(n_issue), 32'd1);
    check_eq("p0_rsp_count", 32'(n_rsp), 32'd1);
    check_eq("p0_rsp_id", 32'(last_id), 32'd0);
    check_eq("p0_rsp_data", 32'(last_data), 32'h01000);
    check_eq("p0_rsp_err", 32'(last_err), 32'd0);

    // All requesters held high from reset: grant order 0,1,2,3,0
    do_reset();
    req_valid = 4'hF; req_data_2 = {3'd3, 3'd3, 3'd3, 3'd3};
    req_data_1 = {10'd100, 10'd200, 10'd300, 10'd400};
    grants.delete();
    for (int i = 0; i < 80 && grants.size() < 5; i++) step();
    check_eq("rr_grant_count", 32'(grants.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < grants.size()) check_eq($sformatf("rr_grant_%0d", i), 32'(grants[i]), 32'(exp_order[i]));
    end
    req_valid = '0;
    for (int i = 0; i < 12; i++) step();

    // Port 2 with degree 0: error response, engine untouched
    n_issue = 0; n_rsp = 0;
    req_valid = 4'b0100; req_data_2[8:6] = 3'd0; req_data_1[29:20] = 10'h155;
    step();
    req_valid = '0;
    for (int i = 0; i < 6; i++) step();
    check_eq("deg0_issue_count", 32'(n_issue), 32'd0);
    check_eq("deg0_rsp_count", 32'(n_rsp), 32'd1);
    check_eq("deg0_rsp_id", 32'(last_id), 32'd2);
    check_eq("deg0_rsp_err", 32'(last_err), 32'd1);
    check_eq("deg0_rsp_data", 32'(last_data), 32'd0);

    // Response back-pressure for 5 cycles
    rsp_ready = 1'b0;
    req_valid = 4'b0010; req_data_2[5:3] = 3'd5; req_data_1[19:10] = 10'd777;
    step();
    req_valid = '0;
    for (int i = 0; i < 20 && !rsp_valid; i++) step();
    check_eq("bp_rsp_reached", 32'(rsp_valid), 32'd1);
    hold_data = rsp_data; hold_id = rsp_id; hold_err = rsp_err;
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_hold_data", 32'(rsp_data), 32'(hold_data));
      check_eq("bp_hold_id", 32'(rsp_id), 32'd1);
      check_eq("bp_hold_err", 32'(rsp_err), 32'(hold_err));
    end
    rsp_ready = 1'b1;
    step();
    #1;
    check_eq("bp_grant_resumes", 32'(|req_ready), 32'd1);
    req_valid = '0;
    for (int i = 0; i < 12; i++) step();

    // Reset pulse while the engine is busy
    eng_silent = 1;
    req_valid = 4'b1000; req_data_2[11:9] = 3'd4; req_data_1[39:30] = 10'd81;
    step();
    req_valid = '0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    eng_silent = 0;
    #1;
    check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("midrst_eng_in_data_2", 32'(eng_in_data_2), 32'd0);
    n_rsp = 0;
    for (int i = 0; i < 4; i++) step();
    check_eq("midrst_no_rsp", 32'(n_rsp), 32'd0);
    req_valid = 4'b0001; req_data_2[2:0] = 3'd3;
    step();
    req_valid = '0;
    for (int i = 0; i < 12; i++) step();
    check_eq("midrst_next_served", 32'(n_rsp), 32'd1);
    check_eq("midrst_next_id", 32'(last_id), 32'd0);

`ifdef ROOT_SCHED_TIMEOUT_EN
    // Silent engine: watchdog fires after TO cycles in WAIT
    eng_silent = 1; n_rsp = 0; n_erst = 0;
    req_valid = 4'b0010; req_data_2[5:3] = 3'd2;
    step();
    req_valid = '0;
    for (int i = 0; i < TO + 8; i++) step();
    eng_silent = 0;
    check_eq("to_rsp_count", 32'(n_rsp), 32'd1);
    check_eq("to_rsp_err", 32'(last_err), 32'd1);
    check_eq("to_rsp_data", 32'(last_data), 32'd0);
    check_eq("to_eng_rst_cycles", 32'(n_erst), 32'd1);
`endif

    // Randomised traffic with spurious engine strobes
    spur_en = 1; eng_lat_max = 5;
    for (int i = 0; i < 1500; i++) begin
      req_valid  = N'($urandom);
      req_data_1 = (N*10)'({$urandom, $urandom});
      req_data_2 = (N*3)'($urandom);
      rsp_ready  = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/root_req_sched.md
ROOT_REQ_SCHED -- requirements
Module: root_req_sched

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one root engine (2..8).
REQ-002 Parameter TIMEOUT_CYC, 255, WAIT-state watchdog limit in cycles (timeout build only).
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  NUM_REQ  per-requester request valid.
REQ-006 req_data_1  in  NUM_REQ*10  per-requester radicand, Q10.0, slice i = bits [10i+9:10i].
REQ-007 req_data_2  in  NUM_REQ*3  per-requester root degree, slice i = bits [3i+2:3i].
REQ-008 req_ready  out  NUM_REQ  one-hot-or-zero accept; transfer when req_valid[i] && req_ready[i].
REQ-009 eng_in_valid  out  1  single-cycle start pulse to engine.
REQ-010 eng_in_data_1  out  10  operand to engine.
REQ-011 eng_in_data_2  out  3  degree to engine.
REQ-012 eng_out_valid  in  1  engine result strobe.
REQ-013 eng_out_data  in  20  engine result, Q10.10.
REQ-014 eng_rst_n  out  1  engine synchronous active-low reset.
REQ-015 rsp_valid  out  1  response valid, held until accepted.
REQ-016 rsp_id  out  clog2(NUM_REQ)  index of requester owning response.
REQ-017 rsp_data  out  20  result, Q10.10.
REQ-018 rsp_err  out  1  job rejected or aborted; rsp_data = 0 when set.
REQ-019 rsp_ready  in  1  response accept.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP; exactly one job in flight.
REQ-021 IDLE: round-robin arbiter picks first valid requester at or after priority pointer; req_ready asserted combinationally for that index only; no req_ready outside IDLE.
REQ-022 On accept: latch operands and id; pointer <= (granted+1) mod NUM_REQ; degree 0 -> RESP with rsp_err=1, engine untouched; else -> ISSUE.
REQ-023 ISSUE: eng_in_valid=1 for exactly one cycle, -> WAIT.
REQ-024 eng_in_data_1/2 driven from latched registers, stable from ISSUE through the eng_out_valid cycle (engine samples degree throughout computation); 0 in IDLE.
REQ-025 WAIT: on eng_out_valid capture eng_out_data into rsp_data, rsp_err=0, -> RESP; eng_out_valid outside WAIT ignored.
REQ-026 RESP: rsp_valid=1, rsp_id/rsp_data/rsp_err stable; on rsp_ready -> IDLE same edge; new grant earliest the following cycle.
REQ-027 Accept-to-eng_in_valid latency 1 cycle; eng_out_valid-to-rsp_valid latency 1 cycle.
REQ-028 Requester dropping req_valid while not granted: no effect; pointer only moves on accept.

Reset
REQ-029 rst_n low: state IDLE, pointer 0, req_ready 0, eng_in_valid 0, eng_in_data_* 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0.
REQ-030 eng_rst_n = 0 while rst_n low; reset mid-job discards job, no response issued.

Configuration
REQ-031 Macro ROOT_SCHED_TIMEOUT_EN defined: WAIT counter from 0; on reaching TIMEOUT_CYC without eng_out_valid, eng_rst_n registered low for exactly one cycle, response rsp_err=1, rsp_data=0, -> RESP.
REQ-032 Macro undefined: no counter, WAIT indefinite, eng_rst_n follows rst_n combinationally.

Structure
REQ-033 Package root_sched_pkg: state enum, IN1_W=10, IN2_W=3, OUT_W=20.
REQ-034 Sub-module rr_arbiter (NUM_REQ-wide, request vector + pointer in, one-hot grant out), combinational.

Verification
REQ-035 Port0 data_1=16 data_2=2, engine model returns 0x01000 -> one eng_in_valid pulse with (16,2), rsp_id=0, rsp_data=0x01000, rsp_err=0.
REQ-036 All four req_valid held high from reset -> grant order 0,1,2,3,0; each req_ready one cycle.
REQ-037 Port2 data_2=0 -> rsp_id=2, rsp_err=1, rsp_data=0, eng_in_valid never asserted.
REQ-038 rsp_ready low 5 cycles in RESP -> response fields constant, req_ready all 0, grant resumes cycle after acceptance.
REQ-039 ROOT_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, silent engine -> eng_rst_n low one cycle after 16 WAIT cycles, rsp_err=1, rsp_data=0.
REQ-040 rst_n low 1 cycle during WAIT -> all outputs at reset values, no response, next request served normally.
